// File: rtl/simple_filter_cfg_seq_pkg.sv
// Shared types and constants for the SimpleFilter configuration sequencer.
package simple_filter_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_FINISH  = 3'd5
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_BRESP    = 2'd1;
    localparam logic [1:0] ERR_RRESP    = 2'd2;
    localparam logic [1:0] ERR_MISMATCH = 2'd3;

    // Registers are 32-bit words on a 4-byte stride.
    function automatic logic [31:0] reg_byte_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/simple_filter_cfg_seq_if.sv
// AXI4-Lite bundle between the sequencer (master) and the filter's S00_AXI port (slave).
interface simple_filter_cfg_seq_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    // Every channel uses strict valid/ready: a transfer occurs on a rising clock edge where
    // both are high; a raised valid stays high with stable payload until its ready.
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/simple_filter_cfg_seq.sv
// Configuration sequencer: writes a captured register table over AXI4-Lite, one transaction
// at a time, optionally reads it back for comparison, and reports busy/done/error status.
module simple_filter_cfg_seq
    import simple_filter_cfg_pkg::*;
#(
    parameter int          C_M_AXI_ADDR_WIDTH = 4,
    parameter int          C_M_AXI_DATA_WIDTH = 32,
    parameter int          NUM_REGS           = 4,
    parameter logic [31:0] BASE_ADDR          = 32'h0,
    localparam int         IDX_W              = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic                    start,
    input  logic                    verify_en,
    input  logic [NUM_REGS*32-1:0]  cfg_data,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              err_code,
    output logic [IDX_W-1:0]        err_index,
    output state_e                  dbg_state_o,
    simple_filter_cfg_seq_if.master m_axi
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    state_e                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     aw_done_q, aw_done_d;
    logic                     w_done_q, w_done_d;
    logic                     verify_q, verify_d;
    logic [NUM_REGS*32-1:0]   cfg_q, cfg_d;
    logic [1:0]               err_code_q, err_code_d;
    logic [IDX_W-1:0]         err_index_q, err_index_d;

    logic [C_M_AXI_DATA_WIDTH-1:0] word_cur;
    logic [C_M_AXI_ADDR_WIDTH-1:0] reg_addr;
    logic aw_hs, w_hs, aw_ok, w_ok;

    assign word_cur = C_M_AXI_DATA_WIDTH'(cfg_q[{idx_q, 5'b00000} +: 32]);
    assign reg_addr = C_M_AXI_ADDR_WIDTH'(reg_byte_addr(BASE_ADDR, 32'(idx_q)));

    // Each write valid drops on its own once its handshake is recorded in the done flag.
    assign m_axi.awvalid = (state_q == ST_WR_REQ) && !aw_done_q;
    assign m_axi.wvalid  = (state_q == ST_WR_REQ) && !w_done_q;
    assign m_axi.awaddr  = (state_q == ST_WR_REQ) ? reg_addr : '0;
    assign m_axi.wdata   = (state_q == ST_WR_REQ) ? word_cur : '0;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.wstrb   = '1;
    assign m_axi.bready  = (state_q == ST_WR_RESP);
    assign m_axi.arvalid = (state_q == ST_RD_REQ);
    assign m_axi.araddr  = (state_q == ST_RD_REQ) ? reg_addr : '0;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.rready  = (state_q == ST_RD_RESP);

    assign aw_hs = m_axi.awvalid && m_axi.awready;
    assign w_hs  = m_axi.wvalid && m_axi.wready;
    assign aw_ok = aw_done_q || aw_hs;
    assign w_ok  = w_done_q || w_hs;

    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_FINISH);
    assign err_code    = err_code_q;
    assign err_index   = err_index_q;
    assign dbg_state_o = state_q;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            verify_q    <= 1'b0;
            cfg_q       <= '0;
            err_code_q  <= ERR_NONE;
            err_index_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            verify_q    <= verify_d;
            cfg_q       <= cfg_d;
            err_code_q  <= err_code_d;
            err_index_q <= err_index_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        verify_d    = verify_q;
        cfg_d       = cfg_q;
        err_code_d  = err_code_q;
        err_index_d = err_index_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cfg_d       = cfg_data;
                    verify_d    = verify_en;
                    err_code_d  = ERR_NONE;
                    err_index_d = '0;
                    idx_d       = '0;
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    state_d     = ST_WR_REQ;
                end
            end
            ST_WR_REQ: begin
                if (aw_ok && w_ok) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = ST_WR_RESP;
                end else begin
                    aw_done_d = aw_ok;
                    w_done_d  = w_ok;
                end
            end
            ST_WR_RESP: begin
                if (m_axi.bvalid) begin
                    if (m_axi.bresp != RESP_OKAY) begin
                        err_code_d  = ERR_BRESP;
                        err_index_d = idx_q;
                        state_d     = ST_FINISH;
                    end else if (idx_q != LAST_IDX) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_WR_REQ;
                    end else if (verify_q) begin
                        idx_d   = '0;
                        state_d = ST_RD_REQ;
                    end else begin
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_RD_REQ: begin
                if (m_axi.arready) begin
                    state_d = ST_RD_RESP;
                end
            end
            ST_RD_RESP: begin
                // A bad response outranks a data mismatch on the same beat.
                if (m_axi.rvalid) begin
                    if (m_axi.rresp != RESP_OKAY) begin
                        err_code_d  = ERR_RRESP;
                        err_index_d = idx_q;
                        state_d     = ST_FINISH;
                    end else if (m_axi.rdata != word_cur) begin
                        err_code_d  = ERR_MISMATCH;
                        err_index_d = idx_q;
                        state_d     = ST_FINISH;
                    end else if (idx_q != LAST_IDX) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_RD_REQ;
                    end else begin
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_simple_filter_cfg_seq.sv
// Directed bench for simple_filter_cfg_seq: vector table run against a configurable
// AXI4-Lite slave model, plus hand-written start-while-busy and mid-sequence reset cases.
`timescale 1ns/1ps
module tb_simple_filter_cfg_seq;
    import simple_filter_cfg_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start;
    logic         verify_en;
    logic [127:0] cfg_data;
    logic         busy;
    logic         done;
    logic [1:0]   err_code;
    logic [1:0]   err_index;
    state_e       dbg_state;

    always #5 clk = ~clk;

    simple_filter_cfg_seq_if #(.ADDR_W(4), .DATA_W(32)) axi ();

    simple_filter_cfg_seq #(
        .C_M_AXI_ADDR_WIDTH(4),
        .C_M_AXI_DATA_WIDTH(32),
        .NUM_REGS(4),
        .BASE_ADDR(32'h0)
    ) dut (
        .ACLK(clk),
        .ARESETN(rst_n),
        .start(start),
        .verify_en(verify_en),
        .cfg_data(cfg_data),
        .busy(busy),
        .done(done),
        .err_code(err_code),
        .err_index(err_index),
        .dbg_state_o(dbg_state),
        .m_axi(axi)
    );

    // ---------------- slave model ----------------
    int          aw_dly = 0, w_dly = 0, berr_idx = -1, cor_idx = -1, rerr_idx = -1;
    logic [1:0]  berr_resp = RESP_SLVERR, rerr_resp = RESP_DECERR;
    int          aw_cnt = 0, w_cnt = 0;
    logic        got_aw = 1'b0, got_w = 1'b0;
    logic [3:0]  lat_addr = '0;
    logic [31:0] lat_data = '0;
    logic [31:0] mem [4];
    logic [35:0] act_q[$];
    logic [35:0] exp_q[$];

    wire aw_hs = axi.awvalid && axi.awready;
    wire w_hs  = axi.wvalid && axi.wready;
    wire ar_hs = axi.arvalid && axi.arready;
    wire have_aw = got_aw || aw_hs;
    wire have_w  = got_w || w_hs;
    wire [3:0]  addr_now = aw_hs ? axi.awaddr : lat_addr;
    wire [31:0] data_now = w_hs ? axi.wdata : lat_data;

    assign axi.awready = axi.awvalid && (aw_cnt >= aw_dly);
    assign axi.wready  = axi.wvalid && (w_cnt >= w_dly);
    assign axi.arready = axi.arvalid;

    always @(posedge clk) begin
        if (!rst_n) begin
            aw_cnt <= 0; w_cnt <= 0; got_aw <= 1'b0; got_w <= 1'b0;
            axi.bvalid <= 1'b0; axi.bresp <= 2'b00;
            axi.rvalid <= 1'b0; axi.rresp <= 2'b00; axi.rdata <= '0;
        end else begin
            if (aw_hs) begin aw_cnt <= 0; lat_addr <= axi.awaddr; end
            else if (axi.awvalid) aw_cnt <= aw_cnt + 1;
            if (w_hs) begin w_cnt <= 0; lat_data <= axi.wdata; end
            else if (axi.wvalid) w_cnt <= w_cnt + 1;
            if (have_aw && have_w) begin
                mem[addr_now[3:2]] <= data_now;
                act_q.push_back({addr_now, data_now});
                axi.bvalid <= 1'b1;
                axi.bresp  <= (int'(addr_now[3:2]) == berr_idx) ? berr_resp : RESP_OKAY;
                got_aw <= 1'b0; got_w <= 1'b0;
            end else begin
                got_aw <= have_aw; got_w <= have_w;
                if (axi.bvalid && axi.bready) axi.bvalid <= 1'b0;
            end
            if (ar_hs) begin
                axi.rvalid <= 1'b1;
                axi.rdata  <= (int'(axi.araddr[3:2]) == cor_idx) ? 32'h0000DEAD : mem[axi.araddr[3:2]];
                axi.rresp  <= (int'(axi.araddr[3:2]) == rerr_idx) ? rerr_resp : RESP_OKAY;
            end else if (axi.rvalid && axi.rready) begin
                axi.rvalid <= 1'b0;
            end
        end
    end

    // ---------------- protocol monitor ----------------
    int          n_aw = 0, n_w = 0, n_ar = 0, n_done = 0, n_unstable = 0;
    logic        aw_pend = 1'b0, w_pend = 1'b0, ar_pend = 1'b0;
    logic [3:0]  aw_hold = '0, ar_hold = '0;
    logic [31:0] w_hold = '0;

    wire aw_bad = aw_pend && (!axi.awvalid || axi.awaddr !== aw_hold);
    wire w_bad  = w_pend && (!axi.wvalid || axi.wdata !== w_hold);
    wire ar_bad = ar_pend && (!axi.arvalid || axi.araddr !== ar_hold);

    always @(posedge clk) begin
        if (done) n_done <= n_done + 1;
        if (!rst_n) begin
            aw_pend <= 1'b0; w_pend <= 1'b0; ar_pend <= 1'b0;
        end else begin
            if (aw_hs) n_aw <= n_aw + 1;
            if (w_hs)  n_w  <= n_w + 1;
            if (ar_hs) n_ar <= n_ar + 1;
            n_unstable <= n_unstable + int'(aw_bad) + int'(w_bad) + int'(ar_bad);
            aw_pend <= axi.awvalid && !axi.awready; aw_hold <= axi.awaddr;
            w_pend  <= axi.wvalid && !axi.wready;   w_hold  <= axi.wdata;
            ar_pend <= axi.arvalid && !axi.arready; ar_hold <= axi.araddr;
        end
    end

    // ---------------- checking ----------------
    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_done(input int first, output int cyc);
        cyc = first;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", done, 1'b1);
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_wr_count"}, act_q.size(), exp_q.size());
        while (exp_q.size() > 0 && act_q.size() > 0)
            chk({tag, "_wr_entry"}, act_q.pop_front(), exp_q.pop_front());
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic load_exp(input logic [127:0] cfg, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back({4'(i * 4), cfg[i*32 +: 32]});
    endtask

    typedef struct {
        logic [127:0] cfg;
        logic         ver;
        int           aw_dly;
        int           w_dly;
        int           berr_idx;
        logic [1:0]   berr_resp;
        int           cor_idx;
        int           rerr_idx;
        logic [1:0]   exp_err;
        logic [1:0]   exp_eidx;
        int           exp_cyc;
        int           exp_wr;
        int           exp_rd;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input int k);
        vec_t  v;
        int    cyc, aw0, w0, ar0;
        string t;
        v = vecs[k];
        t = $sformatf("v%0d", k);
        aw_dly = v.aw_dly; w_dly = v.w_dly;
        berr_idx = v.berr_idx; berr_resp = v.berr_resp;
        cor_idx = v.cor_idx; rerr_idx = v.rerr_idx; rerr_resp = RESP_DECERR;
        act_q.delete();
        load_exp(v.cfg, v.exp_wr);
        aw0 = n_aw; w0 = n_w; ar0 = n_ar;
        start = 1'b1; cfg_data = v.cfg; verify_en = v.ver;
        @(negedge clk);
        start = 1'b0;
        chk({t, "_busy_c1"}, busy, 1'b1);
        chk({t, "_awwvalid_c1"}, {axi.awvalid, axi.wvalid}, 2'b11);
        chk({t, "_err_cleared"}, err_code, ERR_NONE);
        wait_done(1, cyc);
        chk({t, "_cycles"}, cyc, v.exp_cyc);
        chk({t, "_err_code"}, err_code, v.exp_err);
        chk({t, "_err_index"}, err_index, v.exp_eidx);
        repeat (4) @(negedge clk);
        chk({t, "_err_sticky"}, {err_code, err_index}, {v.exp_err, v.exp_eidx});
        chk({t, "_idle_after"}, {busy, dbg_state}, {1'b0, ST_IDLE});
        chk({t, "_n_aw"}, n_aw - aw0, v.exp_wr);
        chk({t, "_n_w"}, n_w - w0, v.exp_wr);
        chk({t, "_n_ar"}, n_ar - ar0, v.exp_rd);
        check_writes(t);
        chk({t, "_stable"}, n_unstable, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc, d0;
        logic [127:0] cfg_a, cfg_b;

        vecs[0] = '{cfg:{32'd4, 32'd3, 32'd2, 32'd1}, ver:1'b1, aw_dly:0, w_dly:0, berr_idx:-1,
                    berr_resp:RESP_SLVERR, cor_idx:-1, rerr_idx:-1, exp_err:ERR_NONE, exp_eidx:2'd0,
                    exp_cyc:17, exp_wr:4, exp_rd:4};
        vecs[1] = '{cfg:{32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0}, ver:1'b1, aw_dly:3,
                    w_dly:1, berr_idx:-1, berr_resp:RESP_SLVERR, cor_idx:-1, rerr_idx:-1,
                    exp_err:ERR_NONE, exp_eidx:2'd0, exp_cyc:29, exp_wr:4, exp_rd:4};
        vecs[2] = '{cfg:{32'h13, 32'h12, 32'h11, 32'h10}, ver:1'b1, aw_dly:0, w_dly:0, berr_idx:2,
                    berr_resp:RESP_SLVERR, cor_idx:-1, rerr_idx:-1, exp_err:ERR_BRESP, exp_eidx:2'd2,
                    exp_cyc:7, exp_wr:3, exp_rd:0};
        vecs[3] = '{cfg:{32'h5555, 32'h4444, 32'h3333, 32'h2222}, ver:1'b1, aw_dly:0, w_dly:0,
                    berr_idx:-1, berr_resp:RESP_SLVERR, cor_idx:1, rerr_idx:-1, exp_err:ERR_MISMATCH,
                    exp_eidx:2'd1, exp_cyc:13, exp_wr:4, exp_rd:2};
        vecs[4] = '{cfg:{32'h5555, 32'h4444, 32'h3333, 32'h2222}, ver:1'b1, aw_dly:0, w_dly:0,
                    berr_idx:-1, berr_resp:RESP_SLVERR, cor_idx:1, rerr_idx:1, exp_err:ERR_RRESP,
                    exp_eidx:2'd1, exp_cyc:13, exp_wr:4, exp_rd:2};
        vecs[5] = '{cfg:{32'hCAFEF00D, 32'h0BADBEEF, 32'h12345678, 32'hFFFFFFFF}, ver:1'b0, aw_dly:0,
                    w_dly:0, berr_idx:-1, berr_resp:RESP_SLVERR, cor_idx:-1, rerr_idx:-1,
                    exp_err:ERR_NONE, exp_eidx:2'd0, exp_cyc:9, exp_wr:4, exp_rd:0};
        vecs[6] = '{cfg:{32'h4, 32'h3, 32'h2, 32'h77}, ver:1'b0, aw_dly:1, w_dly:2, berr_idx:0,
                    berr_resp:RESP_DECERR, cor_idx:-1, rerr_idx:-1, exp_err:ERR_BRESP, exp_eidx:2'd0,
                    exp_cyc:5, exp_wr:1, exp_rd:0};
        vecs[7] = '{cfg:{32'h00000008, 32'h6, 32'h4, 32'h2}, ver:1'b1, aw_dly:0, w_dly:0,
                    berr_idx:-1, berr_resp:RESP_SLVERR, cor_idx:3, rerr_idx:-1,
                    exp_err:ERR_MISMATCH, exp_eidx:2'd3, exp_cyc:17, exp_wr:4, exp_rd:4};

        start = 1'b0; verify_en = 1'b0; cfg_data = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_status", {busy, done, err_code, err_index}, 0);
        chk("rst_valids", {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}, 0);
        chk("rst_payload", {axi.awaddr, axi.araddr, axi.wdata}, 0);
        chk("rst_state", dbg_state, ST_IDLE);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 8; k++) run_vec(k);

        // start while busy and during FINISH must leave the running sequence untouched
        aw_dly = 0; w_dly = 0; berr_idx = -1; cor_idx = -1; rerr_idx = -1;
        cfg_a = {32'h44, 32'h33, 32'h22, 32'h11};
        cfg_b = {32'hF3, 32'hF2, 32'hF1, 32'hF0};
        act_q.delete();
        load_exp(cfg_a, 4);
        d0 = n_ar;
        start = 1'b1; cfg_data = cfg_a; verify_en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; cfg_data = cfg_b; verify_en = 1'b0;
        @(negedge clk);
        start = 1'b0;
        wait_done(3, cyc);
        chk("busy_start_cycles", cyc, 17);
        chk("busy_start_err", err_code, ERR_NONE);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("finish_start_ignored", {busy, dbg_state, axi.awvalid}, {1'b0, ST_IDLE, 1'b0});
        chk("busy_start_n_ar", n_ar - d0, 4);
        check_writes("busy_start");

        // reset during the write response of word 1
        act_q.delete();
        start = 1'b1; cfg_data = cfg_a; verify_en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_rst_in_wr_resp", {dbg_state, axi.bready}, {ST_WR_RESP, 1'b1});
        d0 = n_done;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_status", {busy, done, err_code, err_index}, 0);
        chk("mid_rst_valids", {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}, 0);
        chk("mid_rst_state", dbg_state, ST_IDLE);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_rst_no_done", n_done - d0, 0);
        run_vec(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
